// File: rtl/gray_pkg.sv
// Shared definitions for Gray-domain controllers.
// Holds the FSM state encodings and the requester ID constants.
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/gray_rr_arb.sv
// Two-way round-robin arbiter; purely combinational, the pointer lives in the parent.
// On contention it grants the requester that was not served last.
module gray_rr_arb
  import gray_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       en,
  input  logic       last_id,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req0 && req1) begin
        grant = (last_id == ID_REQ0) ? 2'b10 : 2'b01;
      end else if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/gray_bin_seq_ctrl.sv
// Bit-serial Gray-to-binary converter shared by two requesters, MSB first,
// with results returned on a valid/ready port tagged with the requester ID.
//
// state | meaning
// IDLE  | waiting for a request; grants one and captures its Gray word
// CONV  | resolving one binary bit per cycle, MSB down to bit 0
// DONE  | result presented on bin/out_id until out_ready
module gray_bin_seq_ctrl
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] gray0,
  output logic             ack0,
  input  logic             req1,
  input  logic [WIDTH-1:0] gray1,
  output logic             ack1,
  output logic             busy,
  output logic [WIDTH-1:0] bin,
  output logic             out_id,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] g_reg;
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] bin_up;
  logic [CW-1:0]    cnt;
  logic             id_q;
  logic             last_id;
  logic [1:0]       grant;
  logic             arb_en;

  // Gating with rst_n keeps the acks low while reset is held, even with requests up.
  assign arb_en = (state == IDLE) && rst_n;

  gray_rr_arb u_arb (
    .req0    (req0),
    .req1    (req1),
    .en      (arb_en),
    .last_id (last_id),
    .grant   (grant)
  );

  // bin_up[i] is the already-resolved bit above i; zero above the MSB.
  assign bin_up = {1'b0, bin_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant != 2'b00) state_nxt = CONV;
      CONV: if (cnt == '0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack0      = grant[0];
    ack1      = grant[1];
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    bin       = bin_q;
    out_id    = id_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_reg   <= '0;
      bin_q   <= '0;
      cnt     <= '0;
      id_q    <= ID_REQ0;
      last_id <= ID_REQ1;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            g_reg <= grant[1] ? gray1 : gray0;
            id_q  <= grant[1] ? ID_REQ1 : ID_REQ0;
            cnt   <= CW'(WIDTH - 1);
          end
        end
        CONV: begin
          bin_q[cnt] <= g_reg[cnt] ^ bin_up[cnt];
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          // Pointer advances only on a completed output handshake.
          if (out_ready) last_id <= id_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_bin_seq_ctrl.sv
// Self-checking bench for gray_bin_seq_ctrl (WIDTH=4) against a
// word-level Gray-to-binary reference model.
module tb_gray_bin_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, req1;
  logic [W-1:0] gray0, gray1;
  logic         ack0, ack1;
  logic         busy;
  logic [W-1:0] bin;
  logic         out_id;
  logic         out_valid;
  logic         out_ready;

  int checks   = 0;
  int failures = 0;
  int n_ack    = 0;
  int n_hs     = 0;

  gray_bin_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .gray0     (gray0),
    .ack0      (ack0),
    .req1      (req1),
    .gray1     (gray1),
    .ack1      (ack1),
    .busy      (busy),
    .bin       (bin),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      if (ack0) n_ack++;
      if (ack1) n_ack++;
      if (out_valid && out_ready) n_hs++;
    end
  end

  // Reference: binary bit i is the XOR of all Gray bits at and above i.
  function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request to completion; returns latency from ack to out_valid.
  task automatic do_req(input logic id, input logic [W-1:0] g, input bit rnd,
                        output int lat, output logic [W-1:0] b, output logic oid,
                        output bit ok);
    int n;
    ok = 1'b1; lat = -1; b = '0; oid = 1'b0;
    if (id) begin req1 = 1'b1; gray1 = g; end
    else    begin req0 = 1'b1; gray0 = g; end
    out_ready = rnd ? 1'b0 : 1'b1;
    #1;
    n = 0;
    while (!(id ? ack1 : ack0) && n < 20) begin step(); n++; end
    if (!(id ? ack1 : ack0)) begin
      ok = 1'b0; req0 = 1'b0; req1 = 1'b0;
      return;
    end
    step();
    req0 = 1'b0; req1 = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin step(); n++; end
    if (!out_valid) begin ok = 1'b0; return; end
    lat = n; b = bin; oid = out_id;
    n = 0;
    forever begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_ready || n >= 30) begin
        out_ready = 1'b1;
        step();
        break;
      end
      step();
      n++;
    end
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; gray0 = '0; gray1 = '0; out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, out_valid, ack0, ack1, out_id, bin} !== {5'b0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL reset_state: got busy=%b valid=%b ack=%b%b id=%b bin=%b, want all zero",
               busy, out_valid, ack0, ack1, out_id, bin);
    end
  endtask

  task automatic test_single();
    int lat; logic [W-1:0] b; logic oid; bit ok;
    do_req(1'b0, 4'b1011, 1'b0, lat, b, oid, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_timeout: no ack or no out_valid"); end
    checks++;
    if (lat !== W + 1) begin failures++; $display("FAIL single_latency: got %0d want %0d", lat, W + 1); end
    checks++;
    if (b !== 4'b1101 || oid !== 1'b0) begin
      failures++; $display("FAIL single_result: got bin=%b id=%b want bin=1101 id=0", b, oid);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL single_idle: got busy=%b valid=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_both_ports();
    int lat; logic [W-1:0] b; logic oid; bit ok;
    do_req(1'b0, 4'b0000, 1'b0, lat, b, oid, ok);
    checks++;
    if (!ok || b !== 4'b0000 || oid !== 1'b0) begin
      failures++; $display("FAIL zero_code: got ok=%0d bin=%b id=%b want bin=0000 id=0", ok, b, oid);
    end
    do_req(1'b1, 4'b1000, 1'b0, lat, b, oid, ok);
    checks++;
    if (!ok || b !== 4'b1111 || oid !== 1'b1 || lat !== W + 1) begin
      failures++;
      $display("FAIL req1_code: got ok=%0d bin=%b id=%b lat=%0d want bin=1111 id=1 lat=%0d",
               ok, b, oid, lat, W + 1);
    end
  endtask

  task automatic test_contention();
    logic grants[$];
    logic rid[$];
    logic [W-1:0] rbin[$];
    int n = 0;
    do_reset();
    gray0 = 4'b0110; gray1 = 4'b0111; req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    #1;
    while (rid.size() < 4 && n < 100) begin
      checks++;
      if (ack0 && ack1) begin failures++; $display("FAIL double_ack: both acks high"); end
      if (ack0) grants.push_back(1'b0);
      if (ack1) grants.push_back(1'b1);
      if (out_valid && out_ready) begin rid.push_back(out_id); rbin.push_back(bin); end
      step(); n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (rid.size() != 4 || grants.size() < 4) begin
      failures++; $display("FAIL contention_count: got %0d results %0d grants want 4", rid.size(), grants.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] !== 1'(i % 2) || rid[i] !== 1'(i % 2) ||
            rbin[i] !== ref_bin((i % 2) ? 4'b0111 : 4'b0110)) begin
          failures++;
          $display("FAIL contention_%0d: got grant=%b id=%b bin=%b want id=%0d bin=%b", i,
                   grants[i], rid[i], rbin[i], i % 2, ref_bin((i % 2) ? 4'b0111 : 4'b0110));
        end
      end
    end
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    step();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] b0; logic id0; int n = 0;
    out_ready = 1'b0;
    req1 = 1'b1; gray1 = 4'b1100;
    #1;
    while (!ack1 && n < 20) begin step(); n++; end
    step(); req1 = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    b0 = bin; id0 = out_id;
    checks++;
    if (!out_valid || b0 !== ref_bin(4'b1100) || id0 !== 1'b1) begin
      failures++; $display("FAIL bp_result: got valid=%b bin=%b id=%b want 1 %b 1",
                           out_valid, b0, id0, ref_bin(4'b1100));
    end
    req0 = 1'b1; req1 = 1'b1; gray0 = 4'b0011; gray1 = 4'b0101;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || bin !== b0 || out_id !== id0 || ack0 || ack1) begin
        failures++;
        $display("FAIL bp_hold_%0d: got valid=%b bin=%b id=%b ack=%b%b", i, out_valid, bin, out_id, ack0, ack1);
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [W-1:0] b; logic oid; bit ok; int n = 0;
    req0 = 1'b1; gray0 = 4'b0101;
    #1;
    while (!ack0 && n < 20) begin step(); n++; end
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, ack0, ack1, out_id, bin} !== {5'b0, {W{1'b0}}}) begin
      failures++;
      $display("FAIL mid_reset: got busy=%b valid=%b ack=%b%b id=%b bin=%b want all zero",
               busy, out_valid, ack0, ack1, out_id, bin);
    end
    req0 = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_ghost: got valid=%b want 0", out_valid); end
    do_req(1'b0, 4'b1111, 1'b0, lat, b, oid, ok);
    checks++;
    if (!ok || b !== 4'b1010 || oid !== 1'b0 || lat !== W + 1) begin
      failures++;
      $display("FAIL post_reset: got ok=%0d bin=%b id=%b lat=%0d want bin=1010 id=0 lat=%0d",
               ok, b, oid, lat, W + 1);
    end
  endtask

  task automatic test_sweep();
    int lat; logic [W-1:0] b; logic oid; bit ok;
    int a0, h0;
    logic [W-1:0] codes[16];
    for (int i = 0; i < 16; i++) codes[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      int j = $urandom_range(0, i);
      logic [W-1:0] t = codes[i];
      codes[i] = codes[j]; codes[j] = t;
    end
    a0 = n_ack; h0 = n_hs;
    for (int i = 0; i < 16; i++) begin
      logic id = 1'(i % 2);
      do_req(id, codes[i], 1'b1, lat, b, oid, ok);
      checks++;
      if (!ok || b !== ref_bin(codes[i]) || oid !== id || lat !== W + 1) begin
        failures++;
        $display("FAIL sweep_%0d: gray=%b got bin=%b id=%b lat=%0d want bin=%b id=%b lat=%0d",
                 i, codes[i], b, oid, lat, ref_bin(codes[i]), id, W + 1);
      end
    end
    step();
    checks++;
    if ((n_ack - a0) != (n_hs - h0) || (n_ack - a0) != 16) begin
      failures++; $display("FAIL sweep_counts: got acks=%0d handshakes=%0d want 16 16", n_ack - a0, n_hs - h0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both_ports();
    test_contention();
    test_backpressure();
    test_mid_reset();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
